// File: rtl/tape_pkg.sv
// tape_pkg: shared widths, select opcodes, request/response types and responder FSM states
package tape_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam logic [3:0] PLUS  = 4'h1;
  localparam logic [3:0] MINUS = 4'h2;
  localparam logic [3:0] BRZ   = 4'h5;
  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic                  en;
    logic [DEF_ADDR_W-1:0] addr;
  } rd_req_t;
  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] data;
  } rd_rsp_t;
endpackage

// File: rtl/wq_fifo.sv
// wq_fifo: write-back FIFO (push/pop, full/empty, head entry) with a youngest-match lookup on i_lk_addr
module wq_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_addr,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data,
  input  logic [AW-1:0] i_lk_addr,
  output logic          o_lk_hit,
  output logic [DW-1:0] o_lk_data
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt;
  assign o_full      = r_cnt == (PW+1)'(DEPTH);
  assign o_empty     = r_cnt == '0;
  assign o_head_addr = r_addr[r_rp];
  assign o_head_data = r_data[r_rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + PW'(1);
      if (i_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_wp] <= i_push_addr;
      r_data[r_wp] <= i_push_data;
    end
  end
  always_comb begin
    o_lk_hit  = 1'b0;
    o_lk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < r_cnt && r_addr[r_rp + PW'(k)] == i_lk_addr) begin
        o_lk_hit  = 1'b1;
        o_lk_data = r_data[r_rp + PW'(k)];
      end
    end
  end
endmodule

// File: rtl/tape_mem_responder.sv
// tape_mem_responder: tape array with 2-cycle read responses (rd_*), write-back queue (wr_*), zero-fill (init_done), sticky err
module tape_mem_responder
  import tape_pkg::*;
#(
  parameter int NCORES   = 4,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WQ_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NCORES-1:0]            rd_en,
  input  logic [NCORES*ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  output logic [$clog2(NCORES)-1:0]    rd_dest,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_ready,
  output logic                         init_done,
  output logic [1:0]                   err
);
  localparam int SW = $clog2(NCORES);
  state_t r_state, w_state_nx;
  logic [ADDR_W:0] r_clr_cnt;
  logic [DATA_W-1:0] r_mem [1<<ADDR_W];
  logic [SW-1:0] w_sel, r_s1_dest;
  logic [ADDR_W-1:0] w_rd_addr, w_head_addr;
  logic [DATA_W-1:0] w_head_data, w_fwd, r_ram_q, r_s1_fwd;
  logic w_rd, w_multi, w_clr, w_drain, w_wr_acc, w_full, w_empty, w_hit;
  logic r_s1_valid, r_s1_hit, r_s1_zero;
  always_comb begin
    w_sel = '0;
    for (int i = NCORES-1; i >= 0; i--) if (rd_en[i]) w_sel = SW'(i);
  end
  assign w_rd      = |rd_en;
  assign w_multi   = |(rd_en & (rd_en - NCORES'(1)));
  assign w_rd_addr = rd_addr[w_sel*ADDR_W +: ADDR_W];
  assign w_clr     = r_state == INIT && !w_rd;
  assign w_drain   = r_state == RUN && !w_rd && !w_empty;
  assign w_wr_acc  = wr_en && !w_full;
  assign wr_ready  = !w_full;
  assign init_done = r_state == RUN;
  always_ff @(posedge clk) r_state <= rst ? INIT : w_state_nx;
  always_comb w_state_nx = (w_clr && &r_clr_cnt[ADDR_W-1:0]) ? RUN : r_state;
  always_ff @(posedge clk) begin
    if (rst) r_clr_cnt <= '0;
    else if (w_clr) r_clr_cnt <= r_clr_cnt + (ADDR_W+1)'(1);
  end
  always_ff @(posedge clk) begin
    if (w_rd) r_ram_q <= r_mem[w_rd_addr];
    if (w_clr) r_mem[r_clr_cnt[ADDR_W-1:0]] <= '0;
    else if (w_drain) r_mem[w_head_addr] <= w_head_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_dest  <= '0;
      r_s1_hit   <= 1'b0;
      r_s1_fwd   <= '0;
      r_s1_zero  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_dest    <= '0;
      rd_data    <= '0;
      err        <= '0;
    end else begin
      r_s1_valid <= w_rd;
      r_s1_dest  <= w_sel;
      r_s1_hit   <= w_hit;
      r_s1_fwd   <= w_fwd;
      r_s1_zero  <= r_state == INIT && {1'b0, w_rd_addr} >= r_clr_cnt;
      rd_valid   <= r_s1_valid;
      rd_dest    <= r_s1_dest;
      rd_data    <= r_s1_hit ? r_s1_fwd : r_s1_zero ? '0 : r_ram_q;
      err        <= err | {wr_en && w_full, w_multi};
    end
  end
  wq_fifo #(.DEPTH(WQ_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_wq (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_wr_acc),
    .i_push_addr (wr_addr),
    .i_push_data (wr_data),
    .i_pop       (w_drain),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .i_lk_addr   (w_rd_addr),
    .o_lk_hit    (w_hit),
    .o_lk_data   (w_fwd)
  );
endmodule

// File: tb/tb_tape_mem_responder.sv
// tb_tape_mem_responder: directed, table-driven and random checks against a queue-based reference model
module tb_tape_mem_responder;
  localparam int NC = 4, AW = 4, DW = 16, QD = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [NC-1:0] rd_en = '0;
  logic [NC*AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic rd_valid;
  logic [1:0] rd_dest;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic wr_ready, init_done;
  logic [1:0] err;
  always #5 clk = ~clk;
  tape_mem_responder #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(QD)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_dest(rd_dest), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .init_done(init_done), .err(err)
  );
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int a; int d;} wq_t;
  typedef struct {int due; int dest; int data;} rsp_t;
  typedef struct {logic [3:0] en; logic [1:0] dest; logic err0;} arb_t;
  int m_mem [1<<AW];
  wq_t m_q[$];
  rsp_t m_rsp[$];
  bit m_init = 1'b1;
  int m_clr = 0;
  logic [1:0] m_err = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic model_edge();
    int w, n, a, d;
    bit acc;
    w = -1;
    n = 0;
    if (rst) begin
      m_q.delete();
      m_rsp.delete();
      m_init = 1'b1;
      m_clr = 0;
      m_err = '0;
      return;
    end
    for (int i = NC-1; i >= 0; i--) if (rd_en[i]) begin w = i; n++; end
    if (n > 1) m_err[0] = 1'b1;
    if (w >= 0) begin
      a = int'(rd_addr[w*AW +: AW]);
      d = m_mem[a];
      if (m_init && a >= m_clr) d = 0;
      foreach (m_q[k]) if (m_q[k].a == a) d = m_q[k].d;
      m_rsp.push_back('{cyc + 2, w, d});
    end
    acc = wr_en && m_q.size() < QD;
    if (wr_en && !acc) m_err[1] = 1'b1;
    if (w < 0) begin
      if (m_init) begin
        m_mem[m_clr] = 0;
        m_clr++;
        if (m_clr == (1 << AW)) m_init = 1'b0;
      end else if (m_q.size() > 0) begin
        m_mem[m_q[0].a] = m_q[0].d;
        void'(m_q.pop_front());
      end
    end
    if (acc) m_q.push_back('{int'(wr_addr), int'(wr_data)});
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    if (m_rsp.size() > 0 && m_rsp[0].due == cyc) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, m_rsp[0].data);
      chk("rd_dest", rd_dest, m_rsp[0].dest);
      void'(m_rsp.pop_front());
    end else chk("rd_valid_idle", rd_valid, 0);
    chk("wr_ready", wr_ready, m_q.size() < QD);
    chk("init_done", init_done, !m_init);
    chk("err", err, m_err);
  endtask
  task automatic idle_in();
    rd_en = '0;
    rd_addr = '0;
    wr_en = 1'b0;
  endtask
  task automatic set_rd(input int c, input int a);
    rd_en[c] = 1'b1;
    rd_addr[c*AW +: AW] = AW'(a);
  endtask
  task automatic set_wr(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    arb_t tab[6];
    int n, r;
    tab = '{'{4'b0001, 2'd0, 1'b0}, '{4'b1000, 2'd3, 1'b0}, '{4'b0010, 2'd1, 1'b0},
            '{4'b1100, 2'd2, 1'b1}, '{4'b1111, 2'd0, 1'b1}, '{4'b1010, 2'd1, 1'b1}};
    rst = 1'b1;
    tick();
    tick();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_ready", wr_ready, 1);
    rst = 1'b0;
    n = 0;
    while (!init_done && n < 40) begin tick(); n++; end
    chk("init_cycles", n, 16);
    set_rd(0, 9);
    tick();
    idle_in();
    tick();
    chk("post_init_read", {rd_valid, rd_data}, {1'b1, 16'h0000});
    set_wr(3, 'h1234);
    tick();
    idle_in();
    tick();
    set_rd(2, 3);
    tick();
    chk("lat_c1_valid", rd_valid, 0);
    idle_in();
    tick();
    chk("lat_c2_valid", rd_valid, 1);
    chk("lat_c2_dest", rd_dest, 2);
    chk("lat_c2_data", rd_data, 'h1234);
    tick();
    chk("lat_c3_valid", rd_valid, 0);
    foreach (tab[i]) begin
      idle_in();
      rd_en = tab[i].en;
      tick();
      idle_in();
      tick();
      chk("arb_valid", rd_valid, 1);
      chk("arb_dest", rd_dest, tab[i].dest);
      chk("arb_err0", err[0], tab[i].err0);
    end
    idle_in();
    rd_en = 4'b0110;
    rd_addr[1*AW +: AW] = 4'd3;
    rd_addr[2*AW +: AW] = 4'd0;
    tick();
    chk("multi_err0", err[0], 1);
    idle_in();
    set_rd(3, 3);
    tick();
    chk("multi_dest1", {rd_valid, rd_dest, rd_data}, {1'b1, 2'd1, 16'h1234});
    idle_in();
    tick();
    chk("next_dest3", {rd_valid, rd_dest}, {1'b1, 2'd3});
    idle_in();
    set_rd(0, 5);
    set_wr(5, 'hAA);
    tick();
    set_wr(5, 'hBB);
    tick();
    chk("rbw_old", rd_data, 0);
    wr_en = 1'b0;
    tick();
    chk("fwd_aa", rd_data, 'hAA);
    tick();
    chk("fwd_bb1", rd_data, 'hBB);
    tick();
    chk("fwd_bb2", rd_data, 'hBB);
    idle_in();
    tick();
    chk("fwd_bb3", rd_data, 'hBB);
    tick();
    chk("drained_ready", wr_ready, 1);
    set_rd(1, 5);
    tick();
    idle_in();
    tick();
    chk("array_bb", {rd_valid, rd_data}, {1'b1, 16'h00BB});
    for (int i = 0; i < QD; i++) begin
      idle_in();
      set_rd(1, i);
      set_wr(8 + i, 'h100 + i);
      tick();
    end
    chk("full_ready", wr_ready, 0);
    chk("full_err1_clear", err[1], 0);
    set_wr(9, 'hDEAD);
    tick();
    chk("ovf_err1", err[1], 1);
    chk("ovf_ready", wr_ready, 0);
    rd_en = '0;
    set_wr(9, 'hBEEF);
    tick();
    chk("drain_full_ready", wr_ready, 1);
    idle_in();
    set_rd(0, 9);
    tick();
    idle_in();
    tick();
    chk("lost_write", rd_data, 'h101);
    set_rd(2, 3);
    set_wr(4, 'h44);
    tick();
    idle_in();
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", rd_valid, 0);
    chk("rst_mid_init", init_done, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_ready", wr_ready, 1);
    rst = 1'b0;
    tick();
    chk("rst_mid_valid2", rd_valid, 0);
    for (int t = 0; t < 3000; t++) begin
      idle_in();
      r = $urandom_range(0, 9);
      if (r >= 8) rd_en = 4'($urandom);
      else if (r >= 4) rd_en[$urandom_range(0, NC-1)] = 1'b1;
      rd_addr = (NC*AW)'($urandom);
      if ($urandom_range(0, 2) == 0) set_wr($urandom_range(0, 15), $urandom_range(0, 65535));
      rst = $urandom_range(0, 599) == 0;
      tick();
    end
    idle_in();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
